// File: rtl/cdc_fifo_tt.sv
// rtl/cdc_fifo_tt.sv - 8x8 Gray-pointer FIFO with a clock-enabled slow read side
module cdc_fifo_tt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int SYNC = 2;

    logic          wr_en;
    logic          rd_en;
    logic [1:0]    rd_div;
    logic          unused_uio;

    logic [2:0]    cnt;
    logic          rd_tick;

    logic [DW-1:0] mem [2**AW];

    logic [AW:0]   wbin, wgray, wbin_next, wgray_next;
    logic [AW:0]   rbin, rgray, rbin_next, rgray_next;
    logic [AW:0]   wq [SYNC];
    logic [AW:0]   rq [SYNC];
    logic [AW:0]   wq2, rq2;

    logic          full, empty, overflow, underflow;
    logic          wr_ok, rd_ok;

    assign wr_en      = ena & uio_in[0];
    assign rd_en      = ena & uio_in[1];
    assign rd_div     = uio_in[3:2];
    assign unused_uio = &{1'b0, uio_in[7:4]};

    assign uio_out = {underflow, overflow, empty, full, 4'b0000};
    assign uio_oe  = 8'hF0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 3'd1;
        end
    end

    always_comb begin
        rd_tick = 1'b0;
        case (rd_div)
            2'd0:    rd_tick = 1'b1;
            2'd1:    rd_tick = cnt[0];
            2'd2:    rd_tick = &cnt[1:0];
            default: rd_tick = &cnt;
        endcase
    end

    assign wq2 = wq[SYNC-1];
    assign rq2 = rq[SYNC-1];

    assign wr_ok      = wr_en & ~full;
    assign wbin_next  = wbin + {{AW{1'b0}}, wr_ok};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);

    assign rd_ok      = rd_tick & rd_en & ~empty;
    assign rbin_next  = rbin + {{AW{1'b0}}, rd_ok};
    assign rgray_next = rbin_next ^ (rbin_next >> 1);

    // Storage carries no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wbin[AW-1:0]] <= ui_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin     <= '0;
            wgray    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < SYNC; i++) begin
                rq[i] <= '0;
            end
        end else begin
            wbin  <= wbin_next;
            wgray <= wgray_next;
            // Full when the write pointer has lapped the synchronized read pointer.
            full  <= (wgray_next == {~rq2[AW:AW-1], rq2[AW-2:0]});
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            rq[0] <= rgray;
            for (int i = 1; i < SYNC; i++) begin
                rq[i] <= rq[i-1];
            end
        end
    end

    // Read side advances only on rd_tick, including its view of the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbin      <= '0;
            rgray     <= '0;
            empty     <= 1'b1;
            underflow <= 1'b0;
            uo_out    <= '0;
            for (int i = 0; i < SYNC; i++) begin
                wq[i] <= '0;
            end
        end else if (rd_tick) begin
            rbin  <= rbin_next;
            rgray <= rgray_next;
            empty <= (rgray_next == wq2);
            if (rd_ok) begin
                uo_out <= mem[rbin[AW-1:0]];
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
            wq[0] <= wgray;
            for (int i = 1; i < SYNC; i++) begin
                wq[i] <= wq[i-1];
            end
        end
    end
endmodule

// File: tb/tb_cdc_fifo_tt.sv
// tb/tb_cdc_fifo_tt.sv - randomized queue-model bench for cdc_fifo_tt
`timescale 1ns/1ps
module tb_cdc_fifo_tt;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = '0;
    logic [7:0] uio_in = '0;
    logic [7:0] uo_out, uio_out, uio_oe;

    cdc_fifo_tt dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    wire full  = uio_out[4];
    wire empty = uio_out[5];
    wire ovf   = uio_out[6];
    wire udf   = uio_out[7];

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];
    logic [7:0] exp_out;
    bit         exp_ovf, exp_udf;
    int         m_cnt;
    logic [1:0] div;
    int         cyc;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        uio_in = '0;
        ena = 1'b1;
        @(negedge clk);
        q.delete();
        exp_out = '0; exp_ovf = 0; exp_udf = 0; m_cnt = 0; cyc = 0;
        rst_n = 1'b1;
    endtask

    // One clock of stimulus; the model decides acceptance from the visible flags.
    task automatic cycle(input bit wr, input bit rd, input logic [7:0] d, output bit racc);
        bit tick, wacc;
        uio_in = {4'h0, div, rd, wr};
        ui_in  = d;
        case (div)
            2'd0: tick = 1;
            2'd1: tick = (m_cnt % 2) == 1;
            2'd2: tick = (m_cnt % 4) == 3;
            default: tick = (m_cnt % 8) == 7;
        endcase
        wacc = ena && wr && !full;
        racc = tick && ena && rd && !empty;
        if (ena && wr && full) exp_ovf = 1;
        if (tick && ena && rd && empty) exp_udf = 1;
        if (racc && q.size() > 0) exp_out = q.pop_front();
        if (wacc) q.push_back(d);
        @(posedge clk);
        m_cnt = (m_cnt + 1) % 8;
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit r;
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, r);
    endtask

    task automatic test_reset();
        do_reset();
        idle(3);
        checks++; if (uio_oe !== 8'hF0) begin errors++; $display("FAIL reset_oe got %h want f0", uio_oe); end
        checks++; if (uio_out !== 8'h20) begin errors++; $display("FAIL reset_status got %h want 20", uio_out); end
        checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", uo_out); end
    endtask

    task automatic test_order();
        bit r;
        logic [7:0] v [3];
        v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33;
        do_reset();
        div = 2'd0;
        for (int i = 0; i < 3; i++) cycle(1, 0, v[i], r);
        idle(4);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 8'h00, r);
            checks++; if (uo_out !== v[i]) begin errors++; $display("FAIL order_%0d got %h want %h", i, uo_out, v[i]); end
        end
        for (int i = 0; i < 3 && !empty; i++) idle(1);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL order_empty got %b want 1", empty); end
        checks++; if (udf !== 1'b0) begin errors++; $display("FAIL order_udf got %b want 0", udf); end
    endtask

    task automatic test_full_underflow();
        bit r;
        do_reset();
        div = 2'd0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_early_%0d got %b want 0", i, full); end
            cycle(1, 0, 8'hA0 + 8'(i), r);
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_set got %b want 1", full); end
        cycle(1, 0, 8'hFF, r);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf); end
        idle(4);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 8'h00, r);
            checks++; if (uo_out !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL full_read_%0d got %h want %h", i, uo_out, 8'hA0 + 8'(i)); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty got %b want 1", empty); end
        checks++; if (udf !== 1'b0) begin errors++; $display("FAIL udf_early got %b want 0", udf); end
        cycle(0, 1, 8'h00, r);
        checks++; if (udf !== 1'b1) begin errors++; $display("FAIL udf_set got %b want 1", udf); end
        checks++; if (uo_out !== 8'hA7) begin errors++; $display("FAIL udf_hold got %h want a7", uo_out); end
        idle(5);
        checks++; if (ovf !== 1'b1 || udf !== 1'b1) begin errors++; $display("FAIL sticky got %b%b want 11", ovf, udf); end
    endtask

    task automatic test_wrap();
        bit r;
        logic [7:0] v;
        do_reset();
        div = 2'd0;
        for (int i = 0; i < 20; i++) begin
            v = 8'(i * 37 + 5);
            cycle(1, 0, v, r);
            idle(4);
            cycle(0, 1, 8'h00, r);
            checks++; if (uo_out !== v) begin errors++; $display("FAIL wrap_%0d got %h want %h", i, uo_out, v); end
        end
        checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL wrap_flags got %b%b want 00", ovf, udf); end
    endtask

    task automatic test_ena();
        bit r;
        do_reset();
        div = 2'd0;
        for (int i = 0; i < 3; i++) cycle(1, 0, 8'h50 + 8'(i), r);
        idle(4);
        ena = 1'b0;
        for (int i = 0; i < 6; i++) cycle(1, 1, 8'hEE, r);
        checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL ena_out got %h want 00", uo_out); end
        checks++; if (empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL ena_flags got e%b f%b want e0 f0", empty, full); end
        ena = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 8'h00, r);
            checks++; if (uo_out !== 8'h50 + 8'(i)) begin errors++; $display("FAIL ena_read_%0d got %h want %h", i, uo_out, 8'h50 + 8'(i)); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ena_empty got %b want 1", empty); end
    endtask

    task automatic test_reset_mid();
        bit r;
        for (int n = 5; n <= 8; n += 3) begin
            do_reset();
            div = 2'd0;
            for (int i = 0; i < n; i++) cycle(1, 0, 8'h70 + 8'(i), r);
            idle(4);
            checks++; if (empty !== 1'b0 || full !== (n == 8)) begin errors++; $display("FAIL mid_pre_%0d got e%b f%b", n, empty, full); end
            #2 rst_n = 1'b0;
            #1;
            checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL mid_rst_%0d got e%b f%b want e1 f0", n, empty, full); end
        end
        do_reset();
    endtask

    task automatic test_random();
        bit r, wr, rd;
        logic [7:0] seq, prev;
        int last_chg;
        for (int d = 0; d < 4; d++) begin
            do_reset();
            div = 2'(d);
            seq = 8'h01;
            prev = uo_out;
            last_chg = -100;
            for (int i = 0; i < 400; i++) begin
                wr = $urandom_range(0, 99) < ((d == 3) ? 15 : 50);
                rd = (d == 3) ? 1'b1 : ($urandom_range(0, 99) < 55);
                cycle(wr, rd, seq, r);
                if (wr) seq = seq + 8'd1;
                checks++; if (uo_out !== exp_out) begin errors++; $display("FAIL rand%0d_data c%0d got %h want %h", d, i, uo_out, exp_out); end
                checks++; if (full === 1'b0 && q.size() >= 8) begin errors++; $display("FAIL rand%0d_full c%0d got 0 want 1", d, i); end
                checks++; if (empty === 1'b0 && q.size() == 0) begin errors++; $display("FAIL rand%0d_empty c%0d got 0 want 1", d, i); end
                checks++; if (ovf !== exp_ovf || udf !== exp_udf) begin errors++; $display("FAIL rand%0d_sticky c%0d got %b%b want %b%b", d, i, ovf, udf, exp_ovf, exp_udf); end
                if (d == 3 && uo_out !== prev) begin
                    checks++; if (cyc - last_chg < 8) begin errors++; $display("FAIL rand3_rate c%0d gap %0d want >=8", i, cyc - last_chg); end
                    last_chg = cyc;
                    prev = uo_out;
                end
            end
            for (int i = 0; i < 300 && q.size() > 0; i++) begin
                cycle(0, 1, 8'h00, r);
                checks++; if (uo_out !== exp_out) begin errors++; $display("FAIL drain%0d_data got %h want %h", d, uo_out, exp_out); end
            end
            checks++; if (q.size() != 0) begin errors++; $display("FAIL drain%0d_left got %0d want 0", d, q.size()); end
        end
    endtask

    initial begin
        div = 2'd0;
        exp_out = '0; exp_ovf = 0; exp_udf = 0; m_cnt = 0; cyc = 0;
        test_reset();
        test_order();
        test_full_underflow();
        test_wrap();
        test_ena();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
